quantum_scheduler: RTL
======================

Name: quantum_scheduler

Overview:
- Round-robin preemptive scheduler for the multiprogrammed processor. It generalises the fixed two-program quantum/changeProgram handling to N_PROG programs with a programmable quantum.
- Counts retired instructions and raises save/load handshakes toward the data RAM context store (spc/lpc equivalents).
- Tells the PC and control unit which program runs and when execution is allowed.

Parameters:
N_PROG, 4, number of program slots (2..16)
PIDW, 2, program-id width; must equal clog2(N_PROG)
QW, 8, quantum register width
DEFAULT_QUANTUM, 16, quantum value after reset (1..2^QW-1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latches prog_mask and begins scheduling
prog_mask  input  N_PROG  bit i = program i present
step  input  1  one instruction retired this cycle (divided-clock enable)
def_quantum  input  1  load quantum_in into quantum register
quantum_in  input  QW  new quantum in instructions
end_program  input  1  current program executed its end instruction
save_ack  input  1  context store finished saving cur_pid
load_ack  input  1  context store finished restoring next_pid
save_req  output  1  request save of context cur_pid (level)
load_req  output  1  request restore of context next_pid (level)
cur_pid  output  PIDW  running program
next_pid  output  PIDW  program selected for restore
run_en  output  1  processor may execute
all_done  output  1  every program finished
switch_count  output  16  completed context switches, saturating

Behaviour:
- Reset (async, immediate): state IDLE; save_req, load_req, run_en, all_done, cur_pid, next_pid, switch_count = 0; ready mask = 0; step counter = 0; quantum register = DEFAULT_QUANTUM.
- States: IDLE, LOAD, RUN, SAVE, SELECT, DONE. All outputs are registered.
- IDLE:
  - start with prog_mask != 0: ready <= prog_mask; cur_pid and next_pid <= lowest set bit; go to LOAD. This is the initial load and is not counted.
  - start with prog_mask == 0: go to DONE.
- LOAD:
  - load_req = 1 and next_pid held stable until load_ack.
  - On load_ack: cur_pid <= next_pid; counter <= 0; go to RUN next cycle.
  - switch_count += 1 (saturating at 16'hFFFF) only if LOAD was entered from SELECT.
  - load_req drops in the cycle after load_ack.
- RUN:
  - run_en = 1. Each step increments the counter.
  - Expiry: step while counter == quantum - 1.
  - end_program (takes priority over a simultaneous expiry): ready[cur_pid] <= 0, counter <= 0, go to SELECT with no save.
  - Expiry with another program ready: go to SAVE.
  - Expiry with cur_pid the only ready program: counter <= 0, stay in RUN, no handshake, no count.
  - run_en drops in the cycle after leaving RUN.
- SAVE: save_req = 1 until save_ack, then go to SELECT. save_req drops the cycle after the ack.
- SELECT (one cycle):
  - next_pid <= first ready index scanning cur_pid+1, cur_pid+2, ... modulo N_PROG, with cur_pid checked last.
  - If no program is ready: go to DONE. Otherwise go to LOAD.
- DONE: all_done = 1, run_en = 0. start re-enters the IDLE behaviour (and clears all_done). switch_count is kept.
- def_quantum:
  - Accepted in any state; quantum_in == 0 is stored as 1.
  - Takes effect at the next comparison. If counter >= new quantum - 1, the next step expires.
  - The counter is not cleared.
- Ignored inputs:
  - step and end_program outside RUN.
  - start outside IDLE/DONE.
  - save_ack outside SAVE and load_ack outside LOAD.
- reset asserted mid-handshake aborts immediately; save_req and load_req go low asynchronously.

Test Plan:
1. Reset, def_quantum=1 with quantum_in=3, start with prog_mask=4'b0101, load_ack after 2 cycles:
   - cur_pid=0, run_en=1.
   - After 3 steps: save_req; ack; next_pid=2; load_ack; cur_pid=2, switch_count=1.
2. prog_mask=4'b1111, quantum 2, acks immediate, 16 steps: cur_pid sequence 0,1,2,3,0,...; switch_count=7.
3. prog_mask=4'b0010, quantum 4, 12 steps: save_req and load_req never assert after the initial load; cur_pid stays 1; switch_count=0.
4. prog_mask=4'b0011:
   - end_program while running pid 0: no save_req; next load restores pid 1.
   - end_program on pid 1: all_done=1, run_en=0.
5. Step 5 with quantum 8, then def_quantum=1 with quantum_in=4: next step triggers save_req.
   - Also: def_quantum=1 with quantum_in=0 acts as quantum 1.
6. Assert reset while save_req=1 and switch_count=5: save_req=0, switch_count=0, state IDLE, quantum=16. A start afterwards behaves as after power-up.

Source files
------------

// File: rtl/quantum_scheduler.sv
// Round-robin preemptive scheduler for N_PROG program slots with a programmable quantum.
// Drives the save/load context handshakes and tells the core which program may run.
module quantum_scheduler #(
  parameter int N_PROG          = 4,
  parameter int PIDW            = 2,
  parameter int QW              = 8,
  parameter int DEFAULT_QUANTUM = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N_PROG-1:0] prog_mask,
  input  logic              step,
  input  logic              def_quantum,
  input  logic [QW-1:0]     quantum_in,
  input  logic              end_program,
  input  logic              save_ack,
  input  logic              load_ack,
  output logic              save_req,
  output logic              load_req,
  output logic [PIDW-1:0]   cur_pid,
  output logic [PIDW-1:0]   next_pid,
  output logic              run_en,
  output logic              all_done,
  output logic [15:0]       switch_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAVE   = 3'd3,
    ST_SELECT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [N_PROG-1:0]   ready_r, ready_s;
  logic [QW-1:0]       cnt_r, cnt_s;
  logic [QW-1:0]       quantum_r, quantum_s;
  logic [PIDW-1:0]     cur_pid_r, cur_pid_s;
  logic [PIDW-1:0]     next_pid_r, next_pid_s;
  logic [15:0]         switch_count_r, switch_count_s;
  logic                from_select_r, from_select_s;
  logic                save_req_r, load_req_r, run_en_r, all_done_r;
  logic [PIDW-1:0]     lowest_s;
  logic [PIDW-1:0]     rr_pick_s;
  logic                expire_s;
  logic                other_ready_s;
  logic [N_PROG-1:0]   cur_onehot_s;

  assign save_req     = save_req_r;
  assign load_req     = load_req_r;
  assign cur_pid      = cur_pid_r;
  assign next_pid     = next_pid_r;
  assign run_en       = run_en_r;
  assign all_done     = all_done_r;
  assign switch_count = switch_count_r;

  // Lowest present program and next ready program after cur_pid (cur_pid itself last).
  always_comb begin
    logic [PIDW-1:0] idx;
    lowest_s  = {PIDW{1'b0}};
    rr_pick_s = cur_pid_r;
    idx       = {PIDW{1'b0}};
    for (int i = N_PROG - 1; i >= 0; i--) begin
      idx = PIDW'(i);
      if (prog_mask[idx]) begin
        lowest_s = idx;
      end else begin
        lowest_s = lowest_s;
      end
    end
    // Scan backwards so the earliest position in round-robin order wins.
    for (int i = N_PROG; i >= 1; i--) begin
      idx = PIDW'((int'(cur_pid_r) + i) % N_PROG);
      if (ready_r[idx]) begin
        rr_pick_s = idx;
      end else begin
        rr_pick_s = rr_pick_s;
      end
    end
  end

  assign cur_onehot_s  = N_PROG'(1) << cur_pid_r;
  assign other_ready_s = |(ready_r & ~cur_onehot_s);
  assign expire_s      = step && (cnt_r >= (quantum_r - QW'(1)));

  // Next-state and next-register computation for the scheduler FSM.
  always_comb begin
    state_s        = state_r;
    ready_s        = ready_r;
    cnt_s          = cnt_r;
    cur_pid_s      = cur_pid_r;
    next_pid_s     = next_pid_r;
    switch_count_s = switch_count_r;
    from_select_s  = from_select_r;

    if (def_quantum) begin
      quantum_s = (quantum_in == QW'(0)) ? QW'(1) : quantum_in;
    end else begin
      quantum_s = quantum_r;
    end

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (prog_mask != {N_PROG{1'b0}}) begin
            ready_s       = prog_mask;
            cur_pid_s     = lowest_s;
            next_pid_s    = lowest_s;
            from_select_s = 1'b0;
            state_s       = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (load_ack) begin
          cur_pid_s = next_pid_r;
          cnt_s     = QW'(0);
          state_s   = ST_RUN;
          if (from_select_r && (switch_count_r != 16'hFFFF)) begin
            switch_count_s = switch_count_r + 16'd1;
          end else begin
            switch_count_s = switch_count_r;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (end_program) begin
          ready_s[cur_pid_r] = 1'b0;
          cnt_s              = QW'(0);
          state_s            = ST_SELECT;
        end else if (expire_s) begin
          if (other_ready_s) begin
            state_s = ST_SAVE;
          end else begin
            cnt_s = QW'(0);
          end
        end else if (step) begin
          cnt_s = cnt_r + QW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_SAVE: begin
        if (save_ack) begin
          state_s = ST_SELECT;
        end else begin
          state_s = ST_SAVE;
        end
      end
      ST_SELECT: begin
        if (ready_r == {N_PROG{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          next_pid_s    = rr_pick_s;
          from_select_s = 1'b1;
          state_s       = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      ready_r        <= {N_PROG{1'b0}};
      cnt_r          <= QW'(0);
      quantum_r      <= QW'(DEFAULT_QUANTUM);
      cur_pid_r      <= {PIDW{1'b0}};
      next_pid_r     <= {PIDW{1'b0}};
      switch_count_r <= 16'd0;
      from_select_r  <= 1'b0;
      save_req_r     <= 1'b0;
      load_req_r     <= 1'b0;
      run_en_r       <= 1'b0;
      all_done_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      ready_r        <= ready_s;
      cnt_r          <= cnt_s;
      quantum_r      <= quantum_s;
      cur_pid_r      <= cur_pid_s;
      next_pid_r     <= next_pid_s;
      switch_count_r <= switch_count_s;
      from_select_r  <= from_select_s;
      save_req_r     <= (state_s == ST_SAVE);
      load_req_r     <= (state_s == ST_LOAD);
      run_en_r       <= (state_s == ST_RUN);
      all_done_r     <= (state_s == ST_DONE);
    end
  end

endmodule
